// File: rtl/sram_arbiter_pkg.sv
// Shared constants and types for the MiniMIPS32 SRAM arbiter.
// Holds the outstanding-access state encodings and the grant identifiers
// used by both the arbiter top level and its round-robin helper.
package sram_arbiter_pkg;

  // Outstanding-access state encodings (2-bit, legacy-compatible values)
  localparam logic [1:0] SRAM_IDLE  = 2'd0;
  localparam logic [1:0] SRAM_I_OUT = 2'd1;
  localparam logic [1:0] SRAM_D_OUT = 2'd2;

  // Port identifiers carried by the grant and the last_grant register
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  // Result of one arbitration round: whether anyone won, and who
  typedef struct packed {
    logic valid;
    logic sel;
  } grant_t;

  // The port that should win a tie, given the port served most recently
  function automatic logic rr_winner(input logic last_grant);
    return (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
  endfunction

endpackage

// File: rtl/sram_arbiter_rr.sv
// Two-input round-robin arbiter for the SRAM arbiter.
// A lone eligible port wins outright; when both are eligible the port not
// served most recently wins. last_grant resets to I so D wins the first tie.
module rr_arb2
  import sram_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_elig,
  input  logic   d_elig,
  input  logic   block,
  output grant_t grant
);

  logic last_grant;

  // Pick this cycle's winner; block (flush) suppresses every grant
  always_comb begin
    grant.valid = 1'b0;
    grant.sel   = GRANT_I;
    if (!block) begin
      if (i_elig && d_elig) begin
        grant.valid = 1'b1;
        grant.sel   = rr_winner(last_grant);
      end else if (i_elig) begin
        grant.valid = 1'b1;
        grant.sel   = GRANT_I;
      end else if (d_elig) begin
        grant.valid = 1'b1;
        grant.sel   = GRANT_D;
      end
    end
  end

  // Remember the port served last so the next tie goes the other way
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GRANT_I;
    end else if (grant.valid) begin
      last_grant <= grant.sel;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-ported synchronous SRAM between the instruction-fetch
// and data-memory ports of the MiniMIPS32 pipeline. At most one access is
// issued per cycle; each port is acknowledged one cycle after its grant,
// and a stall request is raised while any port is still waiting.
//
// state      | meaning
// -----------|-----------------------------------------------------------
// SRAM_IDLE  | nothing issued last cycle, no ack this cycle
// SRAM_I_OUT | fetch issued last cycle; i_ack and fetch data this cycle
// SRAM_D_OUT | data access issued last cycle; d_ack (and load data) now
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                cpu_clk_50M,
  input  logic                cpu_rst_n,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic [DATA_W/8-1:0] d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  input  logic                flush,
  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_we,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata,
  output logic                stallreq_mem
);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              d_wr_out;
  logic [DATA_W-1:0] i_hold;
  logic [DATA_W-1:0] d_hold;
  logic              i_elig;
  logic              d_elig;
  grant_t            grant;

  // A port still holds req during its ack cycle, so it is not eligible then
  assign i_elig = i_req && (state != SRAM_I_OUT);
  assign d_elig = d_req && (state != SRAM_D_OUT);

  rr_arb2 u_rr_arb2 (
    .clk    (cpu_clk_50M),
    .rst_n  (cpu_rst_n),
    .i_elig (i_elig),
    .d_elig (d_elig),
    .block  (flush),
    .grant  (grant)
  );

  // Drive the SRAM command for the winning port and choose the next state
  always_comb begin
    sram_en    = 1'b0;
    sram_we    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    state_nxt  = SRAM_IDLE;
    if (grant.valid) begin
      sram_en = 1'b1;
      if (grant.sel == GRANT_D) begin
        sram_we    = d_we;
        sram_addr  = d_addr;
        sram_wdata = d_wdata;
        state_nxt  = SRAM_D_OUT;
      end else begin
        sram_addr = i_addr;
        state_nxt = SRAM_I_OUT;
      end
    end
  end

  // Outstanding-access state; a flush lands here as IDLE since no grant is made
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state <= SRAM_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Remember whether the data access in flight is a store, so its ack
  // does not overwrite the load-data hold register
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      d_wr_out <= 1'b0;
    end else if (grant.valid && (grant.sel == GRANT_D)) begin
      d_wr_out <= |d_we;
    end
  end

  // Acks follow the outstanding state one cycle after the grant; flush cancels them
  assign i_ack = (state == SRAM_I_OUT) && !flush;
  assign d_ack = (state == SRAM_D_OUT) && !flush;

  // Keep the last delivered fetch word visible after its ack
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      i_hold <= '0;
    end else if (i_ack) begin
      i_hold <= sram_rdata;
    end
  end

  // Keep the last delivered load word visible; stores leave it untouched
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      d_hold <= '0;
    end else if (d_ack && !d_wr_out) begin
      d_hold <= sram_rdata;
    end
  end

  assign i_rdata = i_ack ? sram_rdata : i_hold;
  assign d_rdata = (d_ack && !d_wr_out) ? sram_rdata : d_hold;

  assign stallreq_mem = (i_req && !i_ack) || (d_req && !d_ack);

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios followed by
// randomized traffic on both ports, checked by a scoreboard against a
// word-level memory model kept in the bench.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        cpu_rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [3:0]  d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        flush;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata = 32'h0;
  logic        stallreq_mem;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [31:0] data;
  } d_exp_t;

  logic [31:0] i_q[$];
  d_exp_t      d_q[$];
  logic [31:0] exp_i_hold = 32'h0;
  logic [31:0] exp_d_hold = 32'h0;

  logic [31:0] sram_mem[int unsigned];
  logic [31:0] ref_mem[int unsigned];

  sram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .cpu_clk_50M  (clk),
    .cpu_rst_n    (cpu_rst_n),
    .i_req        (i_req),
    .i_addr       (i_addr),
    .i_ack        (i_ack),
    .i_rdata      (i_rdata),
    .d_req        (d_req),
    .d_we         (d_we),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_ack        (d_ack),
    .d_rdata      (d_rdata),
    .flush        (flush),
    .sram_en      (sram_en),
    .sram_we      (sram_we),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata),
    .stallreq_mem (stallreq_mem)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int unsigned w);
    return (w * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // SoC SRAM: read data appears the cycle after sram_en
  always @(posedge clk) begin
    int unsigned w;
    logic [31:0] cur;
    if (sram_en) begin
      w = int'(sram_addr[31:2]);
      cur = sram_mem.exists(w) ? sram_mem[w] : init_word(w);
      sram_rdata <= cur;
      for (int b = 0; b < 4; b++)
        if (sram_we[b]) cur[8*b +: 8] = sram_wdata[8*b +: 8];
      sram_mem[w] = cur;
    end
  end

  function automatic logic [31:0] ref_rd(input logic [31:0] addr);
    int unsigned w;
    w = int'(addr[31:2]);
    return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
  endfunction

  task automatic ref_wr(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] data);
    logic [31:0] cur;
    cur = ref_rd(addr);
    for (int b = 0; b < 4; b++)
      if (we[b]) cur[8*b +: 8] = data[8*b +: 8];
    ref_mem[int'(addr[31:2])] = cur;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_d(input logic wr, input logic [31:0] data);
    d_exp_t e;
    e.wr = wr;
    e.data = data;
    d_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops an expectation whenever a port is acknowledged
  always @(negedge clk) begin
    logic [31:0] ei;
    d_exp_t ed;
    if (cpu_rst_n) begin
      chk("stallreq", stallreq_mem, (i_req & ~i_ack) | (d_req & ~d_ack));
      if (i_ack) begin
        if (i_q.size() == 0) chk("i_ack_unexpected", 1, 0);
        else begin
          ei = i_q.pop_front();
          chk("i_rdata", i_rdata, ei);
          exp_i_hold = ei;
        end
      end
      if (d_ack) begin
        if (d_q.size() == 0) chk("d_ack_unexpected", 1, 0);
        else begin
          ed = d_q.pop_front();
          if (!ed.wr) begin
            chk("d_rdata", d_rdata, ed.data);
            exp_d_hold = ed.data;
          end
        end
      end
    end
  end

  task automatic do_reset();
    cpu_rst_n = 1'b0;
    i_req = 0; d_req = 0; d_we = 0; flush = 0;
    i_q.delete();
    d_q.delete();
    exp_i_hold = 0;
    exp_d_hold = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_i_ack", i_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    chk("rst_sram_en", sram_en, 0);
    chk("rst_sram_we", sram_we, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_stall", stallreq_mem, 0);
    cpu_rst_n = 1'b1;
  endtask

  task automatic i_driver(input int n_txn);
    int gap, k;
    logic got;
    for (int n = 0; n < n_txn; n++) begin
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        i_req = 0;
        repeat (gap) step();
      end
      i_addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      i_req = 1;
      i_q.push_back(ref_rd(i_addr));
      k = 0; got = 0;
      while (!got && k < 6) begin
        @(negedge clk);
        if (i_ack) got = 1; else k++;
      end
      chk("i_ack_latency", {31'h0, got && (k <= 2)}, 1);
      step();
    end
    i_req = 0;
  endtask

  task automatic d_driver(input int n_txn);
    int gap, k;
    logic got;
    for (int n = 0; n < n_txn; n++) begin
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        d_req = 0;
        d_we = 0;
        repeat (gap) step();
      end
      d_addr = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
      d_we = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      d_wdata = $urandom;
      d_req = 1;
      if (d_we != 0) begin
        ref_wr(d_addr, d_we, d_wdata);
        push_d(1'b1, 32'h0);
      end else begin
        push_d(1'b0, ref_rd(d_addr));
      end
      k = 0; got = 0;
      while (!got && k < 6) begin
        @(negedge clk);
        if (d_ack) got = 1; else k++;
      end
      chk("d_ack_latency", {31'h0, got && (k <= 2)}, 1);
      step();
    end
    d_req = 0;
    d_we = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_addr = 0; d_addr = 0; d_wdata = 0;
    sram_mem[32'h100 >> 2] = 32'h24080001;
    ref_mem[32'h100 >> 2]  = 32'h24080001;
    do_reset();

    // Fetch only
    step();
    i_req = 1; i_addr = 32'h100; i_q.push_back(ref_rd(32'h100));
    @(negedge clk);
    chk("t1_en_c0", sram_en, 1);
    chk("t1_addr_c0", sram_addr, 32'h100);
    chk("t1_we_c0", sram_we, 0);
    chk("t1_stall_c0", stallreq_mem, 1);
    step(); @(negedge clk);
    chk("t1_ack_c1", i_ack, 1);
    chk("t1_stall_c1", stallreq_mem, 0);
    chk("t1_en_c1", sram_en, 0);
    step(); i_req = 0; @(negedge clk);
    chk("t1_hold", i_rdata, 32'h24080001);
    chk("t1_ack_c2", i_ack, 0);

    // Conflict from reset: D first, then I
    step(); do_reset();
    i_req = 1; i_addr = 32'h104; i_q.push_back(ref_rd(32'h104));
    d_req = 1; d_we = 0; d_addr = 32'h200; push_d(1'b0, ref_rd(32'h200));
    @(negedge clk);
    chk("t2_addr_c0", sram_addr, 32'h200);
    chk("t2_en_c0", sram_en, 1);
    chk("t2_stall_c0", stallreq_mem, 1);
    step(); @(negedge clk);
    chk("t2_dack_c1", d_ack, 1);
    chk("t2_addr_c1", sram_addr, 32'h104);
    chk("t2_stall_c1", stallreq_mem, 1);
    step(); d_req = 0; @(negedge clk);
    chk("t2_iack_c2", i_ack, 1);
    chk("t2_stall_c2", stallreq_mem, 0);
    step(); i_req = 0;

    // Store with partial byte enables, then read it back
    d_req = 1; d_we = 4'b0011; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
    ref_wr(32'h40, 4'b0011, 32'hDEADBEEF);
    push_d(1'b1, 32'h0);
    @(negedge clk);
    chk("t3_we_c0", sram_we, 4'b0011);
    chk("t3_wdata_c0", sram_wdata, 32'hDEADBEEF);
    chk("t3_addr_c0", sram_addr, 32'h40);
    step(); @(negedge clk);
    chk("t3_dack_c1", d_ack, 1);
    step(); d_req = 0; d_we = 0; @(negedge clk);
    chk("t3_hold", d_rdata, exp_d_hold);
    step();
    d_req = 1; d_addr = 32'h40; push_d(1'b0, ref_rd(32'h40));
    step(); step(); d_req = 0;

    // Sustained contention: grants alternate D, I, D, I ...
    step(); do_reset();
    i_req = 1; i_addr = 32'h300; i_q.push_back(ref_rd(32'h300));
    d_req = 1; d_we = 0; d_addr = 32'h1100; push_d(1'b0, ref_rd(32'h1100));
    for (int k = 0; k < 8; k++) begin
      logic ia, da;
      @(negedge clk);
      chk("t4_en", sram_en, 1);
      chk("t4_grant_addr", sram_addr, (k % 2 == 0) ? d_addr : i_addr);
      ia = i_ack; da = d_ack;
      step();
      if (ia) begin
        i_addr = i_addr + 4;
        i_q.push_back(ref_rd(i_addr));
      end
      if (da) begin
        if (k < 7) begin
          d_addr = d_addr + 4;
          push_d(1'b0, ref_rd(d_addr));
        end else d_req = 0;
      end
    end
    @(negedge clk);
    chk("t4_last_iack", i_ack, 1);
    step(); i_req = 0;

    // Flush the cycle after an I grant
    step();
    i_req = 1; i_addr = 32'h308;
    @(negedge clk);
    chk("t5_en_c0", sram_en, 1);
    chk("t5_addr_c0", sram_addr, 32'h308);
    step();
    flush = 1; i_req = 0;
    d_req = 1; d_we = 0; d_addr = 32'h1110; push_d(1'b0, ref_rd(32'h1110));
    @(negedge clk);
    chk("t5_iack_flush", i_ack, 0);
    chk("t5_en_flush", sram_en, 0);
    chk("t5_ihold_flush", i_rdata, exp_i_hold);
    step();
    flush = 0;
    @(negedge clk);
    chk("t5_d_after_flush", sram_addr, 32'h1110);
    step(); @(negedge clk);
    chk("t5_dack", d_ack, 1);
    step(); d_req = 0;

    // Asynchronous reset in the middle of D_OUT
    d_req = 1; d_addr = 32'h1114; push_d(1'b0, ref_rd(32'h1114));
    @(negedge clk);
    chk("t6_en_c0", sram_en, 1);
    step(); #1;
    chk("t6_dack_before", d_ack, 1);
    #1;
    cpu_rst_n = 0; i_req = 0; d_req = 0;
    d_q.delete(); i_q.delete();
    exp_i_hold = 0; exp_d_hold = 0;
    #1;
    chk("t6_dack_reset", d_ack, 0);
    chk("t6_en_reset", sram_en, 0);
    chk("t6_stall_reset", stallreq_mem, 0);
    chk("t6_drdata_reset", d_rdata, 0);
    step(); cpu_rst_n = 1;
    step();
    i_req = 1; i_addr = 32'h310; i_q.push_back(ref_rd(32'h310));
    d_req = 1; d_addr = 32'h1118; push_d(1'b0, ref_rd(32'h1118));
    @(negedge clk);
    chk("t6_first_conflict_d", sram_addr, 32'h1118);
    step(); @(negedge clk);
    chk("t6_then_i", sram_addr, 32'h310);
    step(); d_req = 0;
    step(); i_req = 0;

    // Randomized traffic on both ports
    step();
    fork
      i_driver(150);
      d_driver(150);
    join
    repeat (4) step();
    chk("i_queue_drained", i_q.size(), 0);
    chk("d_queue_drained", d_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
